// File: rtl/serial_parity_framer.sv
// Framed serial parity unit.
// GEN mode forwards FRAME_BITS data bits through a one-stage output register
// and then appends a parity bit. CHK mode consumes FRAME_BITS data bits plus
// one received parity bit and flags a mismatch. A saturating counter tallies
// CHK mismatches.
module serial_parity_framer #(
    parameter int FRAME_BITS = 8,
    parameter bit ODD        = 1'b1,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                din,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                dout,
    output logic                dout_last,
    output logic                busy,
    output logic                frame_done,
    output logic                parity_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        DONE
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(FRAME_BITS - 1);

    state_t     state;
    logic       mode_q;   // 0 = GEN, 1 = CHK
    logic       acc;
    logic [6:0] cnt;
    logic       accept;

    assign busy   = (state != IDLE);
    assign accept = in_valid & in_ready;

    // Input acceptance: GEN data waits for room in the output stage, CHK
    // takes bits freely through DATA and PAR; abort blocks any handshake.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            DATA:    in_ready = mode_q ? 1'b1 : (!out_valid || out_ready);
            PAR:     in_ready = mode_q;
            default: in_ready = 1'b0;
        endcase
        if (abort) in_ready = 1'b0;
    end

    // Frame FSM with registered output stage, result flags and error counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            acc        <= ODD;
            cnt        <= '0;
            out_valid  <= 1'b0;
            dout       <= 1'b0;
            dout_last  <= 1'b0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            err_cnt    <= '0;
        end else if (abort) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            dout_last  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        mode_q     <= mode;
                        acc        <= ODD;
                        cnt        <= '0;
                        parity_err <= 1'b0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        acc <= acc ^ din;
                        cnt <= cnt + 7'd1;
                        if (!mode_q) begin
                            dout      <= din;
                            dout_last <= 1'b0;
                            out_valid <= 1'b1;
                        end
                        if (cnt == LAST_IDX) state <= PAR;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                PAR: begin
                    if (mode_q) begin
                        if (accept) begin
                            parity_err <= (din != acc);
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (out_valid && dout_last) begin
                        if (out_ready) begin
                            out_valid  <= 1'b0;
                            dout_last  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (!out_valid || out_ready) begin
                        // Parity is loaded only once the last data bit has
                        // left (or is leaving) the output stage.
                        dout      <= acc;
                        dout_last <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    if (mode_q && parity_err && (err_cnt != '1))
                        err_cnt <= err_cnt + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
